uart_rx: RTL and testbench

//  Serial receive front end of the tester: deserialises 8N1 UART frames from the host line.

---
 rtl/uart_rx_pkg.sv | 29 ++
 rtl/uart_rx_if.sv | 21 ++
 rtl/uart_rx_sync_2ff.sv | 23 ++
 rtl/uart_rx.sv | 158 +++++++++++++++
 tb/tb_uart_rx.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM encoding and baud-rate
// derivation helpers used to size the bit-period counter.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

    function automatic int clocks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte hand-off from the UART receiver to its consumer (the command parser).
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       new_rx_data;
    logic       frame_err;
    logic       rx_busy;

    modport master (
        output rx_data,
        output new_rx_data,
        output frame_err,
        output rx_busy
    );

    modport slave (
        input rx_data,
        input new_rx_data,
        input frame_err,
        input rx_busy
    );
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for asynchronous pins; resets to 1 so an idle-high
// line never looks like a start edge coming out of reset.
module sync_2ff (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic meta_r;

    // Two-stage metastability filter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta_r <= 1'b1;
            q      <= 1'b1;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronised line, half-bit start qualification,
// mid-bit data sampling and stop-bit framing check.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic     clk,
    input  logic     rstn,
    input  logic     rx_i,
    uart_rx_if.master rx_if
);

    localparam int DIV   = clocks_per_bit(CLK_HZ, BAUD);
    localparam int CNT_W = clog2(DIV);

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((DIV >> 1) - 1);

    logic            rx_s;
    rx_state_e       state_r, state_nx_s;
    logic [CNT_W-1:0] cnt_r, cnt_nx_s;
    logic [2:0]      bit_idx_r, bit_idx_nx_s;
    logic [7:0]      sh_r, sh_nx_s;

    logic [7:0]      rx_data_r, rx_data_nx_s;
    logic            new_rx_data_r, new_rx_data_nx_s;
    logic            frame_err_r, frame_err_nx_s;
    logic            rx_busy_r, rx_busy_nx_s;

    sync_2ff u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (rx_i),
        .q    (rx_s)
    );

    // State register together with the datapath it sequences
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            bit_idx_r <= 3'd0;
            sh_r      <= 8'h00;
        end else begin
            state_r   <= state_nx_s;
            cnt_r     <= cnt_nx_s;
            bit_idx_r <= bit_idx_nx_s;
            sh_r      <= sh_nx_s;
        end
    end

    // Next-state and datapath update; every phase acts when cnt reaches zero
    always_comb begin
        state_nx_s   = state_r;
        cnt_nx_s     = cnt_r;
        bit_idx_nx_s = bit_idx_r;
        sh_nx_s      = sh_r;
        case (state_r)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_nx_s = ST_START;
                    cnt_nx_s   = CNT_HALF;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_r != CNT_ZERO) begin
                    cnt_nx_s = cnt_r - CNT_ONE;
                end else if (!rx_s) begin
                    state_nx_s   = ST_DATA;
                    cnt_nx_s     = CNT_FULL;
                    bit_idx_nx_s = 3'd0;
                end else begin
                    // Start bit gone at its midpoint: treat as a line glitch
                    state_nx_s = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (cnt_r != CNT_ZERO) begin
                    cnt_nx_s = cnt_r - CNT_ONE;
                end else begin
                    sh_nx_s      = {rx_s, sh_r[7:1]};
                    cnt_nx_s     = CNT_FULL;
                    bit_idx_nx_s = bit_idx_r + 3'd1;
                    if (bit_idx_r == 3'd7) begin
                        state_nx_s = ST_STOP;
                    end else begin
                        state_nx_s = ST_DATA;
                    end
                end
            end
            ST_STOP: begin
                if (cnt_r != CNT_ZERO) begin
                    cnt_nx_s = cnt_r - CNT_ONE;
                end else if (rx_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_BREAK;
                end
            end
            ST_BREAK: begin
                if (rx_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_BREAK;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = CNT_ZERO;
            end
        endcase
    end

    // Output decode: strobes fire only on the stop-bit sample
    always_comb begin
        rx_data_nx_s     = rx_data_r;
        new_rx_data_nx_s = 1'b0;
        frame_err_nx_s   = 1'b0;
        rx_busy_nx_s     = (state_nx_s != ST_IDLE);
        if ((state_r == ST_STOP) && (cnt_r == CNT_ZERO)) begin
            if (rx_s) begin
                rx_data_nx_s     = sh_r;
                new_rx_data_nx_s = 1'b1;
            end else begin
                frame_err_nx_s   = 1'b1;
            end
        end else begin
            new_rx_data_nx_s = 1'b0;
        end
    end

    // Registered outputs so the consumer sees glitch-free strobes
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_data_r     <= 8'h00;
            new_rx_data_r <= 1'b0;
            frame_err_r   <= 1'b0;
            rx_busy_r     <= 1'b0;
        end else begin
            rx_data_r     <= rx_data_nx_s;
            new_rx_data_r <= new_rx_data_nx_s;
            frame_err_r   <= frame_err_nx_s;
            rx_busy_r     <= rx_busy_nx_s;
        end
    end

    assign rx_if.rx_data     = rx_data_r;
    assign rx_if.new_rx_data = new_rx_data_r;
    assign rx_if.frame_err   = frame_err_r;
    assign rx_if.rx_busy     = rx_busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at DIV=10: stimulus queues expected strobes,
// an independent monitor checks kind, data and arrival cycle of each one.
module tb_uart_rx;

    localparam int DIV = 10;
    localparam int LAT = 98;   // cyc at strobe-visible negedge minus cyc at drive negedge

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         exp_cyc;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic rx_i = 1'b1;

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    logic [7:0] last_good = 8'h00;
    exp_t       q[$];
    exp_t       mon_e;

    uart_rx_if rx_if ();

    uart_rx #(.CLK_HZ(1_000_000), .BAUD(100_000)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .rx_i  (rx_i),
        .rx_if (rx_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at a negedge; returns at the negedge ending the stop bit.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok);
        exp_t e;
        rx_i      = 1'b0;
        e.is_err  = !stop_ok;
        e.data    = stop_ok ? d : last_good;
        e.exp_cyc = cyc + LAT;
        if (stop_ok) last_good = d;
        q.push_back(e);
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_i = d[i];
            repeat (DIV) @(negedge clk);
        end
        rx_i = stop_ok;
        repeat (DIV) @(negedge clk);
        rx_i = 1'b1;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_rx_data"},     {24'd0, rx_if.rx_data}, 32'd0);
        chk({tag, "_new_rx_data"}, {31'd0, rx_if.new_rx_data}, 32'd0);
        chk({tag, "_frame_err"},   {31'd0, rx_if.frame_err}, 32'd0);
        chk({tag, "_rx_busy"},     {31'd0, rx_if.rx_busy}, 32'd0);
    endtask

    // Monitor: every strobe must match the oldest queued expectation
    always @(negedge clk) begin
        if (rstn && (rx_if.new_rx_data || rx_if.frame_err)) begin
            chk("strobe_exclusive", {31'd0, rx_if.new_rx_data & rx_if.frame_err}, 32'd0);
            chk("strobe_expected", {31'd0, q.size() != 0}, 32'd1);
            if (q.size() != 0) begin
                mon_e = q.pop_front();
                chk("strobe_kind", {31'd0, rx_if.frame_err}, {31'd0, mon_e.is_err});
                chk("rx_data", {24'd0, rx_if.rx_data}, {24'd0, mon_e.data});
                chk("strobe_cycle", cyc, mon_e.exp_cyc);
            end
        end
    end

    initial begin
        int busy_cnt;
        #1;
        chk_outputs_zero("reset");
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_busy", {31'd0, rx_if.rx_busy}, 32'd0);

        // 1: plain byte, latency checked by the monitor
        send_frame(8'h72, 1'b1);
        repeat (2 * DIV) @(negedge clk);

        // 2: 3-clock low glitch, then a real byte
        rx_i = 1'b0;
        repeat (3) @(negedge clk);
        rx_i = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (rx_if.rx_busy) busy_cnt++;
            @(negedge clk);
        end
        chk("glitch_busy_len", busy_cnt, 5);
        send_frame(8'h65, 1'b1);
        repeat (2 * DIV) @(negedge clk);

        // 3: stop bit low -> framing error, data held
        send_frame(8'h55, 1'b0);
        repeat (2 * DIV) @(negedge clk);
        chk("held_after_ferr", {24'd0, rx_if.rx_data}, 32'h65);

        // 4: back-to-back frames, 100 clocks apart
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        repeat (2 * DIV) @(negedge clk);

        // 5: reset in the middle of bit 4 of 0xA5
        rx_i = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx_i = (i == 1 || i == 3) ? 1'b0 : 1'b1;
            repeat (DIV) @(negedge clk);
        end
        rx_i = 1'b0;
        repeat (DIV / 2) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk_outputs_zero("midframe_reset");
        rx_i      = 1'b1;
        last_good = 8'h00;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_reset_busy", {31'd0, rx_if.rx_busy}, 32'd0);
        send_frame(8'h3C, 1'b1);
        repeat (2 * DIV) @(negedge clk);

        // 6: line held low 25 bit times -> exactly one framing error
        begin
            exp_t e;
            rx_i      = 1'b0;
            e.is_err  = 1'b1;
            e.data    = last_good;
            e.exp_cyc = cyc + LAT;
            q.push_back(e);
        end
        repeat (25 * DIV) @(negedge clk);
        chk("break_busy", {31'd0, rx_if.rx_busy}, 32'd1);
        rx_i = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        chk("break_exit_busy", {31'd0, rx_if.rx_busy}, 32'd0);
        send_frame(8'h0F, 1'b1);

        for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clk);
        chk("queue_drained", q.size(), 32'd0);
        repeat (2 * DIV) @(negedge clk);
        chk("final_rx_data", {24'd0, rx_if.rx_data}, 32'h0F);
        chk("final_busy", {31'd0, rx_if.rx_busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
